// File: rtl/corelet_pkg.sv
// Shared encodings for the corelet sequencer: FSM states, inst word field positions and MAC opcodes.
package corelet_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_FILL = 3'd1,
        W_LOAD = 3'd2,
        W_GAP  = 3'd3,
        X_FILL = 3'd4,
        X_EXEC = 3'd5,
        DRAIN  = 3'd6
    } state_t;

    localparam int INST_W   = 34;
    localparam int MAC_LO   = 0;
    localparam int L0_WR    = 2;
    localparam int L0_RD    = 3;
    localparam int OFIFO_RD = 6;
    localparam int SFP_ACC  = 33;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_KLOAD = 2'b01;
    localparam logic [1:0] OP_EXEC  = 2'b10;

endpackage

// File: rtl/corelet_ctrl.sv
// Corelet sequencer: weight fill/load/settle, activation fill/exec, then drain into SFP, for cfg_nk passes.
// Latency: start at t -> vec_req over t+1..t+row; all outputs registered except inst[OFIFO_RD] and inst[SFP_ACC].
// Backpressure: DRAIN pops only while ofifo_valid; CORELET_CTRL_PERF_EN adds a saturating drain-stall counter.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int row   = 8,
    parameter int col   = 8,
    parameter int CNT_W = 8,
    parameter int KIJ_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_nx,
    input  logic [KIJ_W-1:0]  cfg_nk,
    input  logic              ofifo_valid,
    output logic              vec_req,
    output logic [INST_W-1:0] inst,
    output logic              xw_mode,
    output logic              sfp_reset,
    output logic              busy,
    output logic              done
`ifdef CORELET_CTRL_PERF_EN
    ,
    output logic [CNT_W+KIJ_W-1:0] perf_stall
`endif
);

    localparam int PH_MAX = (row + col > (1 << CNT_W) - 1) ? row + col : (1 << CNT_W) - 1;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] ROW_LAST = PH_W'(row - 1);
    localparam logic [PH_W-1:0] RC_LAST  = PH_W'(row + col - 1);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d, nx_last;
    logic [CNT_W-1:0]  nx_q, pop_q, pop_d;
    logic [KIJ_W-1:0]  nk_q, kij_q, kij_d;
    logic [KIJ_W:0]    kij_inc;
    logic              done_d, sfp_d;
    logic [1:0]        inst_w_q;
    logic              l0_wr_q, l0_rd_q;

    assign nx_last = PH_W'(nx_q) - PH_W'(1);
    assign kij_inc = {1'b0, kij_q} + (KIJ_W+1)'(1);

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q + PH_W'(1);
        pop_d   = pop_q;
        kij_d   = kij_q;
        done_d  = 1'b0;
        sfp_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_nx == '0 || cfg_nk == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = W_FILL;
                        kij_d   = '0;
                        sfp_d   = 1'b1;
                    end
                end
            end
            W_FILL: if (ph_q == ROW_LAST) state_d = W_LOAD;
            W_LOAD: if (ph_q == RC_LAST)  state_d = W_GAP;
            W_GAP:  if (ph_q == ROW_LAST) state_d = X_FILL;
            X_FILL: if (ph_q == nx_last)  state_d = X_EXEC;
            X_EXEC: if (ph_q == nx_last)  state_d = DRAIN;
            DRAIN: begin
                if (ofifo_valid) begin
                    if (pop_q == nx_q - CNT_W'(1)) begin
                        kij_d = kij_inc[KIJ_W-1:0];
                        if (kij_inc == {1'b0, nk_q}) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = W_FILL;
                        end
                    end else begin
                        pop_d = pop_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) ph_d = '0;
        if (state_d != DRAIN) pop_d = '0;
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            pop_q     <= '0;
            kij_q     <= '0;
            nx_q      <= '0;
            nk_q      <= '0;
            vec_req   <= 1'b0;
            xw_mode   <= 1'b0;
            sfp_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            inst_w_q  <= OP_NOP;
            l0_wr_q   <= 1'b0;
            l0_rd_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            pop_q     <= pop_d;
            kij_q     <= kij_d;
            if (state_q == IDLE && start) begin
                nx_q <= cfg_nx;
                nk_q <= cfg_nk;
            end
            vec_req   <= (state_d == W_FILL) || (state_d == X_FILL);
            xw_mode   <= state_d inside {W_FILL, W_LOAD, W_GAP};
            sfp_reset <= sfp_d;
            busy      <= (state_d != IDLE);
            done      <= done_d;
            inst_w_q  <= (state_d == W_LOAD) ? OP_KLOAD :
                         (state_d == X_EXEC) ? OP_EXEC  : OP_NOP;
            l0_rd_q   <= state_d inside {W_LOAD, X_EXEC};
            // L0 write trails the request by one cycle, matching the memory's read latency.
            l0_wr_q   <= vec_req;
        end
    end

    always_comb begin
        inst                = '0;
        inst[MAC_LO +: 2]   = inst_w_q;
        inst[L0_WR]         = l0_wr_q;
        inst[L0_RD]         = l0_rd_q;
        inst[OFIFO_RD]      = (state_q == DRAIN) && ofifo_valid;
        inst[SFP_ACC]       = (state_q == DRAIN);
    end

`ifdef CORELET_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall <= '0;
        end else if (state_q == IDLE && start) begin
            perf_stall <= '0;
        end else if (state_q == DRAIN && !ofifo_valid && perf_stall != '1) begin
            perf_stall <= perf_stall + (CNT_W+KIJ_W)'(1);
        end
    end
`endif

endmodule
